// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for the EXE stage.
// Executes MULT, MULTU, DIV and DIVU over WIDTH/BITS_PER_CYCLE cycles and
// returns a HI/LO pair, announced by a one-cycle done pulse.
// Handshake: start is a request taken only while the unit is idle (busy=0)
// and cancel=0; done is high for exactly the single cycle in which hi/lo
// first hold the new result; cancel aborts at any time with no done.
module muldiv_iter #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N   = WIDTH / BITS_PER_CYCLE;
    localparam int CW  = $clog2(N + 1);
    localparam int BPC = BITS_PER_CYCLE;

    localparam logic [CW-1:0]    CNT_LAST = CW'(N - 1);
    localparam logic [WIDTH:0]   MAG_ONE  = (WIDTH + 1)'(1);
    localparam logic [WIDTH:0]   MAG_MIN  = MAG_ONE << (WIDTH - 1);
    localparam logic [WIDTH-1:0] LO_OVF   = {1'b1, {(WIDTH - 1){1'b0}}};

    // Reject parameter combinations the datapath cannot handle.
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("muldiv_iter: WIDTH must be even and at least 4");
    end
    if (!(BPC == 1 || BPC == 2 || BPC == 4) || (WIDTH % BPC) != 0) begin : g_bad_bpc
        $error("muldiv_iter: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // FSM-derived strobes
    logic accept;   // operation accepted this cycle
    logic finish;   // last CALC cycle, results load at the coming edge

    // Operand decode and magnitudes (W+1 bits keep |-2^(W-1)| exact)
    logic           sign_a;
    logic           sign_b;
    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [WIDTH:0] abs_a;
    logic [WIDTH:0] abs_b;

    // Latched operation context
    logic             is_div_q;
    logic             neg_q;      // product / quotient must be negated
    logic             neg_rem_q;  // remainder takes the dividend's sign
    logic [WIDTH-1:0] src1_q;     // raw dividend for the divide-by-zero result
    logic [WIDTH:0]   mag_a;
    logic [WIDTH:0]   mag_b;
    logic [CW-1:0]    cnt;

    // Shared accumulator: multiply {partial product, multiplier},
    // divide {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;

    // Multiply step intermediates
    logic [WIDTH+BPC-1:0] mul_pp;
    logic [WIDTH+BPC-1:0] mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    // Divide step intermediates
    logic [WIDTH:0]     div_rs;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;
    logic [2*WIDTH-1:0] div_next;

    // Sign-corrected results
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // State register; reset or a mid-operation reset discards any work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and strobes; cancel overrides everything, including start.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        finish   = 1'b0;
        if (cancel) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nx = S_CALC;
                        accept   = 1'b1;
                    end
                end
                S_CALC: begin
                    if (cnt == CNT_LAST) begin
                        state_nx = S_DONE;
                        finish   = 1'b1;
                    end
                end
                S_DONE: begin
                    state_nx = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Operand signs and magnitudes; unsigned ops see both signs as zero.
    always_comb begin
        sign_a = ~op[0] & src1[WIDTH-1];
        sign_b = ~op[0] & src2[WIDTH-1];
        ext_a  = {sign_a, src1};
        ext_b  = {sign_b, src2};
        abs_a  = sign_a ? (~ext_a + MAG_ONE) : ext_a;
        abs_b  = sign_b ? (~ext_b + MAG_ONE) : ext_b;
    end

    // Shift-add: fold BPC multiplier bits into the upper half, then shift right.
    always_comb begin
        mul_pp = '0;
        for (int j = 0; j < BPC; j++) begin
            if (acc[j]) begin
                mul_pp = mul_pp + ({{BPC{1'b0}}, mag_a[WIDTH-1:0]} << j);
            end
        end
        mul_sum  = {{BPC{1'b0}}, acc[2*WIDTH-1:WIDTH]} + mul_pp;
        mul_next = (2*WIDTH)'({mul_sum, acc[WIDTH-1:0]} >> BPC);
    end

    // Restoring division: BPC shift/compare/subtract steps per cycle.
    always_comb begin
        div_rem = acc[2*WIDTH-1:WIDTH];
        div_quo = acc[WIDTH-1:0];
        div_rs  = '0;
        for (int j = 0; j < BPC; j++) begin
            div_rs = {div_rem, div_quo[WIDTH-1]};
            if (div_rs >= mag_b) begin
                div_rem = WIDTH'(div_rs - mag_b);
            end else begin
                div_rem = div_rs[WIDTH-1:0];
            end
            div_quo = {div_quo[WIDTH-2:0], (div_rs >= mag_b)};
        end
        div_next = {div_rem, div_quo};
    end

    assign acc_step = is_div_q ? div_next : mul_next;

    // Sign correction and the divide special cases, applied to the final step.
    always_comb begin
        prod   = neg_q ? (~acc_step + (2*WIDTH)'(1)) : acc_step;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            res_lo = neg_q     ? (~acc_step[WIDTH-1:0] + WIDTH'(1))
                               : acc_step[WIDTH-1:0];
            res_hi = neg_rem_q ? (~acc_step[2*WIDTH-1:WIDTH] + WIDTH'(1))
                               : acc_step[2*WIDTH-1:WIDTH];
            if (mag_b == '0) begin
                res_lo = '1;
                res_hi = src1_q;
            end else if (neg_rem_q && !neg_q && mag_a == MAG_MIN && mag_b == MAG_ONE) begin
                // -2^(W-1) / -1 does not fit; return the most negative quotient.
                res_lo = LO_OVF;
                res_hi = '0;
            end
        end
    end

    // Operand capture on accept, one iteration per CALC cycle otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            src1_q    <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            cnt       <= '0;
            acc       <= '0;
        end else if (accept) begin
            is_div_q  <= op[1];
            neg_q     <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            src1_q    <= src1;
            mag_a     <= abs_a;
            mag_b     <= abs_b;
            cnt       <= '0;
            acc       <= op[1] ? {{WIDTH{1'b0}}, abs_a[WIDTH-1:0]}
                               : {{WIDTH{1'b0}}, abs_b[WIDTH-1:0]};
        end else if (state == S_CALC && !cancel) begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
        end
    end

    // HI/LO change only when entering DONE and hold until the next completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (finish) begin
            hi <= res_hi;
            lo <= res_lo;
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: one instance at BITS_PER_CYCLE=1, one at 4.
// Drivers push the expected HI/LO and done cycle into per-instance queues;
// monitors pop and compare whenever an instance raises done.
module tb_muldiv_iter;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam int LAT_A = 33;  // N+1 at BPC=1
    localparam int LAT_B = 9;   // N+1 at BPC=4

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic        start_a, start_b, cancel;
    logic [1:0]  op;
    logic [31:0] src1, src2;
    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] hi_a, lo_a, hi_b, lo_b;

    muldiv_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .op(op),
        .src1(src1), .src2(src2), .cancel(cancel),
        .busy(busy_a), .done(done_a), .hi(hi_a), .lo(lo_a)
    );

    muldiv_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .op(op),
        .src1(src1), .src2(src2), .cancel(cancel),
        .busy(busy_b), .done(done_b), .hi(hi_b), .lo(lo_b)
    );

    // ---------------- scoreboard ----------------
    logic [63:0] exp_a_q[$];
    int          cyc_a_q[$];
    logic [63:0] exp_b_q[$];
    int          cyc_b_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] e_a, e_b;
    int          ec_a, ec_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the BPC=1 instance
    always @(negedge clk) begin
        if (reset === 1'b0 && done_a === 1'b1) begin
            if (exp_a_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done_a: done=1 with nothing pending (cycle %0d)", cyc);
            end else begin
                e_a  = exp_a_q.pop_front();
                ec_a = cyc_a_q.pop_front();
                check("result_a", {hi_a, lo_a}, e_a);
                check("latency_a", 64'(cyc), 64'(ec_a));
            end
        end
    end

    // Monitor for the BPC=4 instance
    always @(negedge clk) begin
        if (reset === 1'b0 && done_b === 1'b1) begin
            if (exp_b_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done_b: done=1 with nothing pending (cycle %0d)", cyc);
            end else begin
                e_b  = exp_b_q.pop_front();
                ec_b = cyc_b_q.pop_front();
                check("result_b", {hi_b, lo_b}, e_b);
                check("latency_b", 64'(cyc), 64'(ec_b));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge: raises start and records the expectation.
    task automatic drive(input bit sel, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit expect_it, input logic [63:0] e);
        op   = o;
        src1 = a;
        src2 = b;
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        if (expect_it) begin
            if (sel) begin
                exp_b_q.push_back(e);
                cyc_b_q.push_back(cyc + LAT_B);
            end else begin
                exp_a_q.push_back(e);
                cyc_a_q.push_back(cyc + LAT_A);
            end
        end
    endtask

    task automatic wait_idle(input bit sel);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((sel ? busy_b : busy_a) !== 1'b0 && k < 200);
        if ((sel ? busy_b : busy_a) !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_idle_%0d: busy still high after %0d cycles", sel, k);
        end
    endtask

    task automatic wait_done_a();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done_a !== 1'b1 && k < 200);
        if (done_a !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_done_a: no done after %0d cycles", k);
        end
    endtask

    task automatic run(input bit sel, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] e);
        @(negedge clk);
        drive(sel, o, a, b, 1'b1, e);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        wait_idle(sel);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        cancel  = 1'b0;
        op      = OP_MULT;
        src1    = '0;
        src2    = '0;
        repeat (3) @(negedge clk);
        check("reset_busy_a", busy_a, 1'b0);
        check("reset_done_a", done_a, 1'b0);
        check("reset_hilo_a", {hi_a, lo_a}, 64'h0);
        check("reset_busy_b", busy_b, 1'b0);
        check("reset_hilo_b", {hi_b, lo_b}, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors, BPC=1
        run(0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        run(0, OP_MULT,  32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB);
        run(0, OP_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
        run(0, OP_DIVU,  32'h00000007, 32'h00000000, 64'h00000007_FFFFFFFF);
        run(0, OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run(0, OP_DIV,   32'hFFFFFFFB, 32'h00000000, 64'hFFFFFFFB_FFFFFFFF);
        run(0, OP_DIVU,  32'd100,      32'd7,        64'h00000002_0000000E);
        run(0, OP_DIV,   32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
        run(0, OP_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000);
        run(0, OP_MULTU, 32'h12345678, 32'h00000010, 64'h00000001_23456780);
        run(0, OP_MULT,  32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run(0, OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF);
        run(0, OP_DIV,   32'h80000000, 32'h00000001, 64'h00000000_80000000);

        // Directed vectors, BPC=4
        run(1, OP_MULT,  32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB);
        run(1, OP_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
        run(1, OP_DIVU,  32'd100,      32'd7,        64'h00000002_0000000E);
        run(1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        run(1, OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);

        // start held high for the whole operation: one done, no re-latch
        @(negedge clk);
        drive(0, OP_MULTU, 32'd6, 32'd7, 1'b1, 64'h00000000_0000002A);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            src1 = 32'd100;
            src2 = 32'd100;
            if (done_a === 1'b1) break;
        end
        start_a = 1'b0;
        wait_idle(0);
        repeat (40) @(negedge clk);

        // Back-to-back: second start in the first IDLE cycle
        @(negedge clk);
        drive(0, OP_DIVU, 32'd1000, 32'd10, 1'b1, 64'h00000000_00000064);
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a();
        @(negedge clk);
        check("b2b_idle_gap", busy_a, 1'b0);
        drive(0, OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, 64'hFFFFFFFF_FFFFFFFA);
        @(negedge clk);
        start_a = 1'b0;
        wait_idle(0);

        // Cancel in CALC cycle 10, then start and cancel together
        @(negedge clk);
        drive(0, OP_MULTU, 32'd9, 32'd9, 1'b0, 64'h0);
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        check("cancel_busy", busy_a, 1'b0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cancel  = 1'b0;
        check("start_cancel_busy", busy_a, 1'b0);
        check("cancel_hold_hilo", {hi_a, lo_a}, 64'hFFFFFFFF_FFFFFFFA);
        repeat (40) @(negedge clk);
        check("cancel_still_idle", busy_a, 1'b0);
        check("cancel_hold_late", {hi_a, lo_a}, 64'hFFFFFFFF_FFFFFFFA);

        // Asynchronous reset between edges, mid-CALC
        @(negedge clk);
        drive(0, OP_MULTU, 32'd123, 32'd456, 1'b0, 64'h0);
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", busy_a, 1'b0);
        check("async_rst_done", done_a, 1'b0);
        check("async_rst_hilo", {hi_a, lo_a}, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run(0, OP_MULTU, 32'd3, 32'd5, 64'h00000000_0000000F);

        repeat (5) @(negedge clk);
        check("pending_a", 64'(exp_a_q.size()), 64'h0);
        check("pending_b", 64'(exp_b_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
